// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared forwarding select codes and stage-record type
// Contents:
//   FWD_REGFILE / FWD_EX_MM / FWD_MM_WB : EX operand-mux select codes
//   fwd_stage_t                          : shadow destination info for one stage
//   fwd_produces()                       : producer-match predicate for one stage
package mips_pipe_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX_MM   = 2'b01;
    localparam logic [1:0] FWD_MM_WB   = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } fwd_stage_t;

    // $0 is hard-wired to zero, so a write to it never produces a forwardable value.
    function automatic logic fwd_produces(input fwd_stage_t s,
                                          input logic [4:0]  src,
                                          input logic        uses);
        return s.valid & s.reg_write & (s.dest != 5'd0) & (s.dest == src) & uses;
    endfunction

endpackage

// File: rtl/forwarding_control_unit_if.sv
// rtl/forwarding_control_unit_if.sv - RR-stage request / EX forwarding response bundle
// Signals:
//   rr_*                 : RR-stage instruction description (master -> slave)
//   flush_rr_ex, freeze  : pipeline control (master -> slave)
//   Forwarding_control_* : registered EX operand selects (slave -> master)
//   stall_rr             : combinational load-use stall (slave -> master)
//   stall_count          : saturating stall counter (slave -> master)
interface forwarding_control_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   rr_valid;
    logic [4:0]             rr_rs;
    logic [4:0]             rr_rt;
    logic                   rr_uses_rs;
    logic                   rr_uses_rt;
    logic [4:0]             rr_dest;
    logic                   rr_reg_write;
    logic                   rr_mem_read;
    logic                   flush_rr_ex;
    logic                   freeze;
    logic [1:0]             Forwarding_control_1;
    logic [1:0]             Forwarding_control_2;
    logic                   stall_rr;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output rr_valid, rr_rs, rr_rt, rr_uses_rs, rr_uses_rt,
               rr_dest, rr_reg_write, rr_mem_read, flush_rr_ex, freeze,
        input  Forwarding_control_1, Forwarding_control_2, stall_rr, stall_count
    );

    modport slave (
        input  rr_valid, rr_rs, rr_rt, rr_uses_rs, rr_uses_rt,
               rr_dest, rr_reg_write, rr_mem_read, flush_rr_ex, freeze,
        output Forwarding_control_1, Forwarding_control_2, stall_rr, stall_count
    );
endinterface

// File: rtl/forwarding_select.sv
// rtl/forwarding_select.sv - per-operand forwarding code and EX load-match detection
// Ports:
//   src_i, uses_i    : source register of the RR instruction and whether it is read
//   ex_i, mm_i       : current EX and MM shadow stage records
//   code_o           : next select code for this operand
//   ex_load_match_o  : the EX producer of this operand is a load (load-use hazard)
module forwarding_select
    import mips_pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       uses_i,
    input  fwd_stage_t ex_i,
    input  fwd_stage_t mm_i,
    output logic [1:0] code_o,
    output logic       ex_load_match_o
);

    logic ex_match;
    logic mm_match;

    assign ex_match = fwd_produces(ex_i, src_i, uses_i);
    assign mm_match = fwd_produces(mm_i, src_i, uses_i);

    // EX is checked first: it holds the younger write to the same register.
    always_comb begin
        code_o = FWD_REGFILE;
        if (ex_match) begin
            code_o = FWD_EX_MM;
        end else if (mm_match) begin
            code_o = FWD_MM_WB;
        end
    end

    assign ex_load_match_o = ex_match & ex_i.mem_read;

endmodule

// File: rtl/forwarding_control_unit.sv
// rtl/forwarding_control_unit.sv - EX forwarding selects and RR load-use stall
// Ports:
//   clk, rst_n : pipeline clock (rising edge), asynchronous active-low reset
//   bus        : forwarding_control_unit_if slave modport (RR inputs, codes, stall, counter)
module forwarding_control_unit
    import mips_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    forwarding_control_unit_if.slave     bus
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    fwd_stage_t             ex_q, ex_d;
    fwd_stage_t             mm_q, mm_d;
    logic [1:0]             fwd1_q, fwd1_d;
    logic [1:0]             fwd2_q, fwd2_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] code1;
    logic [1:0] code2;
    logic       load_match1;
    logic       load_match2;
    logic       stall;
    logic       bubble;

    forwarding_select u_sel_rs (
        .src_i           (bus.rr_rs),
        .uses_i          (bus.rr_uses_rs),
        .ex_i            (ex_q),
        .mm_i            (mm_q),
        .code_o          (code1),
        .ex_load_match_o (load_match1)
    );

    forwarding_select u_sel_rt (
        .src_i           (bus.rr_rt),
        .uses_i          (bus.rr_uses_rt),
        .ex_i            (ex_q),
        .mm_i            (mm_q),
        .code_o          (code2),
        .ex_load_match_o (load_match2)
    );

    // Flush outranks the stall: a killed instruction must not hold the front end.
    assign stall  = bus.rr_valid & ~bus.flush_rr_ex & (load_match1 | load_match2);

    // Anything that is not a live, issuing instruction enters EX as a bubble
    // and needs no forwarding.
    assign bubble = ~bus.rr_valid | bus.flush_rr_ex | stall;

    always_comb begin
        ex_d   = '0;
        mm_d   = ex_q;
        fwd1_d = FWD_REGFILE;
        fwd2_d = FWD_REGFILE;
        cnt_d  = cnt_q;
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.dest      = bus.rr_dest;
            ex_d.reg_write = bus.rr_reg_write;
            ex_d.mem_read  = bus.rr_mem_read;
            fwd1_d         = code1;
            fwd2_d         = code2;
        end
        if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mm_q   <= '0;
            fwd1_q <= FWD_REGFILE;
            fwd2_q <= FWD_REGFILE;
            cnt_q  <= '0;
        end else if (!bus.freeze) begin
            ex_q   <= ex_d;
            mm_q   <= mm_d;
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Forwarding_control_1 = fwd1_q;
    assign bus.Forwarding_control_2 = fwd2_q;
    assign bus.stall_rr             = stall;
    assign bus.stall_count          = cnt_q;

endmodule

// File: tb/tb_forwarding_control_unit.sv
// tb/tb_forwarding_control_unit.sv - table-driven bench for forwarding_control_unit
module tb_forwarding_control_unit;

    logic clk;
    logic rst_n;

    forwarding_control_unit_if #(.STALL_CNT_W(16)) if_m ();
    forwarding_control_unit_if #(.STALL_CNT_W(4))  if_s ();

    forwarding_control_unit #(.STALL_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    forwarding_control_unit #(.STALL_CNT_W(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s.slave)
    );

    assign if_s.rr_valid     = if_m.rr_valid;
    assign if_s.rr_rs        = if_m.rr_rs;
    assign if_s.rr_rt        = if_m.rr_rt;
    assign if_s.rr_uses_rs   = if_m.rr_uses_rs;
    assign if_s.rr_uses_rt   = if_m.rr_uses_rt;
    assign if_s.rr_dest      = if_m.rr_dest;
    assign if_s.rr_reg_write = if_m.rr_reg_write;
    assign if_s.rr_mem_read  = if_m.rr_mem_read;
    assign if_s.flush_rr_ex  = if_m.flush_rr_ex;
    assign if_s.freeze       = if_m.freeze;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       st;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [22];
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] dest, input logic rw, input logic mr,
                                input logic fl, input logic st,
                                input logic [1:0] f1, input logic [1:0] f2,
                                input logic [15:0] cnt);
        vec_t r;
        r.v = 1'b1; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.dest = dest; r.rw = rw; r.mr = mr; r.fl = fl;
        r.st = st; r.f1 = f1; r.f2 = f2; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic fl);
        if_m.rr_valid     = 1'b1;
        if_m.rr_rs        = rs;
        if_m.rr_rt        = rt;
        if_m.rr_uses_rs   = urs;
        if_m.rr_uses_rt   = urt;
        if_m.rr_dest      = dest;
        if_m.rr_reg_write = rw;
        if_m.rr_mem_read  = mr;
        if_m.flush_rr_ex  = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        if_m.rr_valid = 1'b0; if_m.rr_rs = '0; if_m.rr_rt = '0;
        if_m.rr_uses_rs = 1'b0; if_m.rr_uses_rt = 1'b0; if_m.rr_dest = '0;
        if_m.rr_reg_write = 1'b0; if_m.rr_mem_read = 1'b0;
        if_m.flush_rr_ex = 1'b0; if_m.freeze = 1'b0;

        //            rs  rt  urs urt dest rw mr fl  st f1     f2     cnt
        tbl[0]  = mk(1,  2,  1,  1,  3,  1, 0, 0,  0, 2'b00, 2'b00, 0); // add $3
        tbl[1]  = mk(1,  3,  1,  1,  6,  1, 0, 0,  0, 2'b00, 2'b01, 0); // sub rt=$3
        tbl[2]  = mk(1,  2,  1,  1,  7,  1, 0, 0,  0, 2'b00, 2'b00, 0);
        tbl[3]  = mk(1,  2,  1,  1,  3,  1, 0, 0,  0, 2'b00, 2'b00, 0); // add $3
        tbl[4]  = mk(1,  2,  1,  1, 11,  1, 0, 0,  0, 2'b00, 2'b00, 0); // unrelated
        tbl[5]  = mk(3, 12,  1,  1, 13,  1, 0, 0,  0, 2'b10, 2'b00, 0); // or rs=$3
        tbl[6]  = mk(1,  0,  1,  0,  5,  1, 1, 0,  0, 2'b00, 2'b00, 0); // lw $5
        tbl[7]  = mk(5,  5,  1,  1, 14,  1, 0, 0,  1, 2'b00, 2'b00, 1); // add $5,$5 stalls
        tbl[8]  = mk(5,  5,  1,  1, 14,  1, 0, 0,  0, 2'b10, 2'b10, 1); // replay
        tbl[9]  = mk(1,  2,  1,  1,  0,  1, 0, 0,  0, 2'b00, 2'b00, 1); // write $0
        tbl[10] = mk(0,  0,  1,  1, 15,  1, 0, 0,  0, 2'b00, 2'b00, 1); // read $0
        tbl[11] = mk(1,  2,  1,  1,  4,  1, 0, 0,  0, 2'b00, 2'b00, 1); // add $4
        tbl[12] = mk(1,  0,  1,  0,  4,  1, 0, 0,  0, 2'b00, 2'b00, 1); // addi $4
        tbl[13] = mk(4,  4,  1,  1, 16,  1, 0, 0,  0, 2'b01, 2'b01, 1); // EX beats MM
        tbl[14] = mk(1,  0,  1,  0,  9,  1, 1, 0,  0, 2'b00, 2'b00, 1); // lw $9
        tbl[15] = mk(9, 20,  1,  1, 17,  1, 0, 1,  0, 2'b00, 2'b00, 1); // load-use + flush
        tbl[16] = mk(9, 20,  1,  1, 17,  1, 0, 0,  0, 2'b10, 2'b00, 1);
        tbl[17] = mk(1,  0,  1,  0, 10,  1, 1, 0,  0, 2'b00, 2'b00, 1); // lw $10
        tbl[18] = mk(10, 0,  1,  0, 11,  1, 1, 0,  1, 2'b00, 2'b00, 2); // lw $11 <- $10
        tbl[19] = mk(10, 0,  1,  0, 11,  1, 1, 0,  0, 2'b10, 2'b00, 2);
        tbl[20] = mk(11, 0,  1,  0, 12,  1, 0, 0,  1, 2'b00, 2'b00, 3); // add <- $11
        tbl[21] = mk(11, 0,  1,  0, 12,  1, 0, 0,  0, 2'b10, 2'b00, 3);

        #1;
        chk("reset_f1",    {30'd0, if_m.Forwarding_control_1}, 32'd0);
        chk("reset_f2",    {30'd0, if_m.Forwarding_control_2}, 32'd0);
        chk("reset_stall", {31'd0, if_m.stall_rr}, 32'd0);
        chk("reset_cnt",   {16'd0, if_m.stall_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drv(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                tbl[i].dest, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, if_m.stall_rr}, {31'd0, tbl[i].st});
            tick();
            chk($sformatf("v%0d_f1", i),  {30'd0, if_m.Forwarding_control_1}, {30'd0, tbl[i].f1});
            chk($sformatf("v%0d_f2", i),  {30'd0, if_m.Forwarding_control_2}, {30'd0, tbl[i].f2});
            chk($sformatf("v%0d_cnt", i), {16'd0, if_m.stall_count}, {16'd0, tbl[i].cnt});
        end

        // Freeze for three cycles while a load-use stall is pending.
        drv(12, 0, 1, 0, 5, 1, 1, 0);             // lw $5 reading $12 from EX
        #1;
        chk("frz_lw_stall", {31'd0, if_m.stall_rr}, 32'd0);
        tick();
        chk("frz_lw_f1", {30'd0, if_m.Forwarding_control_1}, 32'd1);
        drv(5, 5, 1, 1, 13, 1, 0, 0);
        #1;
        chk("frz_pre_stall", {31'd0, if_m.stall_rr}, 32'd1);
        if_m.freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_stall", k), {31'd0, if_m.stall_rr}, 32'd1);
            chk($sformatf("frz%0d_f1", k), {30'd0, if_m.Forwarding_control_1}, 32'd1);
            chk($sformatf("frz%0d_f2", k), {30'd0, if_m.Forwarding_control_2}, 32'd0);
            chk($sformatf("frz%0d_cnt", k), {16'd0, if_m.stall_count}, 32'd3);
        end
        if_m.freeze = 1'b0;
        tick();
        chk("unfrz_f1",  {30'd0, if_m.Forwarding_control_1}, 32'd0);
        chk("unfrz_cnt", {16'd0, if_m.stall_count}, 32'd4);
        #1;
        chk("unfrz_stall", {31'd0, if_m.stall_rr}, 32'd0);
        tick();
        chk("replay_f1",  {30'd0, if_m.Forwarding_control_1}, 32'd2);
        chk("replay_f2",  {30'd0, if_m.Forwarding_control_2}, 32'd2);
        chk("replay_cnt", {16'd0, if_m.stall_count}, 32'd4);

        // Asynchronous reset in the middle of a stall.
        drv(13, 0, 1, 0, 5, 1, 1, 0);             // lw $5 reading $13 from EX
        tick();
        chk("rst_lw_f1", {30'd0, if_m.Forwarding_control_1}, 32'd1);
        drv(5, 0, 1, 0, 6, 1, 0, 0);
        #1;
        chk("rst_pre_stall", {31'd0, if_m.stall_rr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_stall", {31'd0, if_m.stall_rr}, 32'd0);
        chk("rst_f1",    {30'd0, if_m.Forwarding_control_1}, 32'd0);
        chk("rst_cnt",   {16'd0, if_m.stall_count}, 32'd0);
        chk("rst_cnt_s", {28'd0, if_s.stall_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", {31'd0, if_m.stall_rr}, 32'd0);
        tick();
        chk("post_rst_f1", {30'd0, if_m.Forwarding_control_1}, 32'd0);

        // Repeated load-use pairs: one stall each; the 4-bit counter saturates.
        for (int n = 1; n <= 20; n++) begin
            drv(1, 0, 1, 0, 5, 1, 1, 0);
            tick();
            drv(5, 0, 1, 0, 6, 1, 0, 0);
            tick();
            if (n == 15) begin
                chk("sat15_small", {28'd0, if_s.stall_count}, 32'd15);
                chk("sat15_big",   {16'd0, if_m.stall_count}, 32'd15);
            end
        end
        chk("sat_small", {28'd0, if_s.stall_count}, 32'd15);
        chk("sat_big",   {16'd0, if_m.stall_count}, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
